dds_sweep_ctrl: RTL

//   Sequencer that drives the FreqWord/PhaseShift inputs of the DDS table-lookup core.

---
 rtl/dds_sweep_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// Sample-strobe divider and linear frequency-sweep sequencer for the DDS core.
// Generates ClkEn, steps FreqWord through single/sawtooth/triangle ramps and forwards PhaseIn on strobes.
module dds_sweep_ctrl #(
   parameter int PHASE_W = 32,
   parameter int DWELL_W = 16,
   parameter int CLK_DIV = 10
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic               Abort,
   input  logic [1:0]         Mode,
   input  logic [PHASE_W-1:0] StartWord,
   input  logic [PHASE_W-1:0] StopWord,
   input  logic [PHASE_W-1:0] StepWord,
   input  logic [DWELL_W-1:0] DwellTicks,
   input  logic [PHASE_W-1:0] PhaseIn,
   output logic               ClkEn,
   output logic [PHASE_W-1:0] FreqWord,
   output logic [PHASE_W-1:0] PhaseShift,
   output logic               Busy,
   output logic               Done,
   output logic               Dir,
   output logic [1:0]         DbgState
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q;
   logic               clk_en_q;
   logic [PHASE_W-1:0] freq_q, freq_d;
   logic [PHASE_W-1:0] phase_q;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DWELL_W-1:0] dwell_ld_q, dwell_ld_d;
   logic [1:0]         mode_q, mode_d;
   logic [PHASE_W-1:0] start_q, start_d;
   logic [PHASE_W-1:0] stop_q, stop_d;
   logic [PHASE_W-1:0] step_q, step_d;
   logic [PHASE_W:0]   up_sum, dn_diff;
   logic [PHASE_W-1:0] up_next, dn_next;
   logic               degen;

   // Free-running divider; ClkEn is registered so it is high while the count sits at CLK_DIV-1.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q    <= '0;
         clk_en_q <= 1'b0;
      end else begin
         div_q    <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
         clk_en_q <= (div_q == DIV_PRE);
      end
   end

   // Steps are computed one bit wider so the ramp clamps at the end words instead of wrapping.
   always_comb begin
      up_sum  = {1'b0, freq_q} + {1'b0, step_q};
      dn_diff = {1'b0, freq_q} - {1'b0, step_q};
      up_next = (up_sum > {1'b0, stop_q}) ? stop_q : up_sum[PHASE_W-1:0];
      dn_next = (dn_diff[PHASE_W] || (dn_diff[PHASE_W-1:0] < start_q)) ? start_q
                                                                        : dn_diff[PHASE_W-1:0];
      degen   = (start_q >= stop_q) || (step_q == '0);
   end

   // Handshake: Start is accepted only in IDLE with Abort low; Busy rises on the accepting edge
   // and falls when the sweep leaves RUN/DONE. Abort dominates Start and never produces Done.
   always_comb begin
      state_d    = state_q;
      freq_d     = freq_q;
      dir_d      = dir_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      dwell_d    = dwell_q;
      dwell_ld_d = dwell_ld_q;
      mode_d     = mode_q;
      start_d    = start_q;
      stop_d     = stop_q;
      step_d     = step_q;
      case (state_q)
         S_IDLE: begin
            if (Start && !Abort) begin
               mode_d     = Mode;
               start_d    = StartWord;
               stop_d     = StopWord;
               step_d     = StepWord;
               dwell_ld_d = (DwellTicks == '0) ? DWELL_W'(1) : DwellTicks;
               dwell_d    = (DwellTicks == '0) ? DWELL_W'(1) : DwellTicks;
               freq_d     = StartWord;
               dir_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_RUN;
            end
         end
         S_RUN: begin
            if (Abort) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else if (clk_en_q) begin
               if (dwell_q > DWELL_W'(1)) begin
                  dwell_d = dwell_q - 1'b1;
               end else begin
                  dwell_d = dwell_ld_q;
                  if (degen) begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else if (!dir_q) begin
                     if (freq_q == stop_q) begin
                        case (mode_q)
                           2'b01:   freq_d = start_q;
                           2'b10: begin
                              dir_d  = 1'b1;
                              freq_d = dn_next;
                           end
                           default: begin
                              done_d  = 1'b1;
                              state_d = S_DONE;
                           end
                        endcase
                     end else begin
                        freq_d = up_next;
                     end
                  end else if (freq_q == start_q) begin
                     dir_d  = 1'b0;
                     freq_d = up_next;
                  end else begin
                     freq_d = dn_next;
                  end
               end
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         freq_q     <= '0;
         phase_q    <= '0;
         dir_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dwell_q    <= '0;
         dwell_ld_q <= '0;
         mode_q     <= '0;
         start_q    <= '0;
         stop_q     <= '0;
         step_q     <= '0;
      end else begin
         state_q    <= state_d;
         freq_q     <= freq_d;
         dir_q      <= dir_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dwell_q    <= dwell_d;
         dwell_ld_q <= dwell_ld_d;
         mode_q     <= mode_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         step_q     <= step_d;
         if (clk_en_q) phase_q <= PhaseIn;
      end
   end

   assign ClkEn      = clk_en_q;
   assign FreqWord   = freq_q;
   assign PhaseShift = phase_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign Dir        = dir_q;
   assign DbgState   = state_q;

endmodule
